// File: rtl/ifetch_unit.sv
// Instruction fetch unit: single-outstanding request FSM feeding the IF/ID register.
// Optional performance counters are enabled with `define IFETCH_PERF_CNT_EN.
module ifetch_unit #(
  parameter int                 PC_SIZE   = 32,
  parameter int                 INST_SIZE = 32,
  parameter logic [PC_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_in,
  input  logic                 redirect_valid,
  input  logic [PC_SIZE-1:0]   redirect_pc,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [PC_SIZE-1:0]   imem_req_addr,
  input  logic                 imem_resp_valid,
  input  logic [INST_SIZE-1:0] imem_resp_data,
  output logic [PC_SIZE-1:0]   IFID_PCplus4_in,
  output logic [INST_SIZE-1:0] inst,
  output logic                 inst_valid,
  output logic [31:0]          fetch_count,
  output logic [31:0]          bubble_count
);

  localparam logic [INST_SIZE-1:0] BUBBLE = INST_SIZE'(32'hF0F0F0F0);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT, S_DRAIN} state_t;

  typedef struct packed {
    logic                 valid;
    logic [PC_SIZE-1:0]   pc4;
    logic [INST_SIZE-1:0] inst;
  } ifid_t;

  state_t               state, state_n;
  logic [PC_SIZE-1:0]   pc, pc_plus4, redir_pc;
  ifid_t                ifid;
  logic                 load, release_out;
  logic                 unused_redir_lsb;

  // Instructions are word aligned; the low redirect bits carry no meaning here.
  assign redir_pc         = {redirect_pc[PC_SIZE-1:2], 2'b00};
  assign unused_redir_lsb = ^redirect_pc[1:0];
  assign pc_plus4         = pc + PC_SIZE'(4);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_REQ;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_REQ:   if (!redirect_valid && imem_req_ready) state_n = S_WAIT;
      S_WAIT:  if (redirect_valid)       state_n = imem_resp_valid ? S_REQ : S_DRAIN;
               else if (imem_resp_valid) state_n = S_OUT;
      S_OUT:   if (redirect_valid || !stall_in) state_n = S_REQ;
      // The drained response always ends DRAIN, even alongside a redirect.
      S_DRAIN: if (imem_resp_valid) state_n = S_REQ;
      default: state_n = S_REQ;
    endcase
  end

  always_comb begin
    imem_req_valid = reset && (state == S_REQ) && !redirect_valid;
    imem_req_addr  = pc;
    load           = (state == S_WAIT) && imem_resp_valid && !redirect_valid;
    release_out    = (state == S_OUT) && (redirect_valid || !stall_in);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              pc <= RESET_PC;
    else if (redirect_valid) pc <= redir_pc;
    else if (load)           pc <= pc_plus4;
  end

  // pc4 is only rewritten on load so it holds through bubbles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifid <= '{valid: 1'b0, pc4: '0, inst: BUBBLE};
    end else if (load) begin
      ifid <= '{valid: 1'b1, pc4: pc_plus4, inst: imem_resp_data};
    end else if (release_out) begin
      ifid.valid <= 1'b0;
      ifid.inst  <= BUBBLE;
    end
  end

  assign inst_valid      = ifid.valid;
  assign inst            = ifid.inst;
  assign IFID_PCplus4_in = ifid.pc4;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fcnt, bcnt;

  // A redirect flushes the presented instruction, so it is not counted as consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fcnt <= '0;
      bcnt <= '0;
    end else begin
      if (ifid.valid && !stall_in && !redirect_valid) fcnt <= fcnt + 32'd1;
      if (!ifid.valid)                                bcnt <= bcnt + 32'd1;
    end
  end

  assign fetch_count  = fcnt;
  assign bubble_count = bcnt;
`else
  assign fetch_count  = '0;
  assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus random traffic against a transaction-level model.
module tb_ifetch_unit;
  localparam logic [31:0] BUBBLE = 32'hF0F0F0F0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_in = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid, imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic [31:0] IFID_PCplus4_in, inst, fetch_count, bubble_count;
  logic        inst_valid;

  always #5 clk = ~clk;

  ifetch_unit #(.PC_SIZE(32), .INST_SIZE(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .stall_in(stall_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .IFID_PCplus4_in(IFID_PCplus4_in),
    .inst(inst), .inst_valid(inst_valid),
    .fetch_count(fetch_count), .bubble_count(bubble_count)
  );

  int checks = 0, errors = 0;

  // Reference model: fetch-stream view (next address, one pending fetch, presented word).
  logic [31:0] exp_pc, pend_addr, pres_inst, pres_pc4;
  bit          pend, pend_live, pres_valid;
  int unsigned consumed, bubbles, presented;

  // Memory: one outstanding request, response after mem_cnt cycles.
  bit          mem_busy, stale;
  int          mem_cnt, lat_fix;
  logic [31:0] mem_addr;
  logic        last_rq;
  logic [31:0] last_addr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h0) ? 32'h01000000 : ((a * 32'h9E3779B1) ^ 32'h00001234);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic rq, hs, rsp;
    logic [31:0] ad;
    rsp = (mem_busy && mem_cnt == 1) || stale;
    imem_resp_valid = rsp;
    imem_resp_data  = stale ? 32'hDEADBEEF : (rsp ? memf(mem_addr) : 32'h0BAD0BAD);
    #1;
    rq = imem_req_valid;
    ad = imem_req_addr;
    chk("req_valid", {31'b0, rq}, {31'b0, !pend && !pres_valid && !redirect_valid});
    if (rq) chk("req_addr", ad, exp_pc);
    last_rq = rq; last_addr = ad;
    hs = rq && imem_req_ready;
    @(posedge clk);
    if (!pres_valid) bubbles++;
    if (pres_valid && (redirect_valid || !stall_in)) begin
      if (!redirect_valid) consumed++;
      pres_valid = 0;
    end
    if (pend && rsp) begin
      if (pend_live && !redirect_valid) begin
        pres_valid = 1;
        pres_inst  = memf(pend_addr);
        pres_pc4   = pend_addr + 32'd4;
        exp_pc     = pend_addr + 32'd4;
        presented++;
      end
      pend = 0;
    end
    if (redirect_valid) begin
      exp_pc    = {redirect_pc[31:2], 2'b00};
      pend_live = 0;
    end
    if (hs) begin pend = 1; pend_live = 1; pend_addr = ad; end
    if (mem_busy) begin
      if (mem_cnt == 1) mem_busy = 0;
      else mem_cnt--;
    end
    if (hs) begin
      mem_busy = 1; mem_addr = ad;
      mem_cnt  = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
    end
    stale = 0;
    @(negedge clk);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, pres_valid});
    chk("inst", inst, pres_valid ? pres_inst : BUBBLE);
    chk("pc_plus4", IFID_PCplus4_in, pres_pc4);
`ifdef IFETCH_PERF_CNT_EN
    chk("fetch_count", fetch_count, consumed);
    chk("bubble_count", bubble_count, bubbles);
`else
    chk("fetch_count", fetch_count, 32'h0);
    chk("bubble_count", bubble_count, 32'h0);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b0; redirect_valid = 1'b0; stall_in = 1'b0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0;
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_inst", inst, BUBBLE);
    chk("rst_pc_plus4", IFID_PCplus4_in, 32'h0);
    chk("rst_fetch_count", fetch_count, 32'h0);
    chk("rst_bubble_count", bubble_count, 32'h0);
    exp_pc = 32'h0; pend = 0; pend_live = 0; pres_valid = 0;
    pres_inst = BUBBLE; pres_pc4 = 32'h0; consumed = 0; bubbles = 0;
    mem_busy = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_held_req_valid", {31'b0, imem_req_valid}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    stale = 1;  // a leftover response from before reset shows up at release
  endtask

  task automatic run_until_valid(input string tag);
    for (int i = 0; i < 20 && inst_valid !== 1'b1; i++) cycle();
    chk(tag, {31'b0, inst_valid}, 32'h1);
  endtask

  initial begin
    presented = 0; lat_fix = 1; stale = 0;
    @(negedge clk);
    do_reset();

    // First fetch: addr 0 in cycle 0, presented in cycle 2.
    cycle();
    chk("first_addr", last_addr, 32'h0);
    cycle();
    chk("first_inst", inst, 32'h01000000);
    chk("first_pc4", IFID_PCplus4_in, 32'h4);
    chk("first_valid", {31'b0, inst_valid}, 32'h1);

    // Stall holds the presented word with no new request.
    stall_in = 1'b1;
    repeat (3) begin
      cycle();
      chk("stall_inst", inst, 32'h01000000);
      chk("stall_pc4", IFID_PCplus4_in, 32'h4);
    end
    stall_in = 1'b0;
    cycle();
    lat_fix = 3;
    cycle();
    chk("after_stall_rq", {31'b0, last_rq}, 32'h1);
    chk("after_stall_addr", last_addr, 32'h4);

    // Redirect while waiting: in-flight response discarded.
    redirect_valid = 1'b1; redirect_pc = 32'h00000103;
    cycle();
    redirect_valid = 1'b0;
    for (int n = 0; n < 10; n++) begin
      cycle();
      if (last_rq) break;
    end
    chk("redir_rq", {31'b0, last_rq}, 32'h1);
    chk("redir_addr", last_addr, 32'h00000100);
    run_until_valid("redir_fetch_timeout");
    cycle();

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFE;
    cycle();
    redirect_valid = 1'b0; lat_fix = 1;
    cycle();
    cycle();
    chk("wrap_valid", {31'b0, inst_valid}, 32'h1);
    chk("wrap_pc4", IFID_PCplus4_in, 32'h0);
    cycle();
    cycle();
    chk("wrap_next_addr", last_addr, 32'h0);
    run_until_valid("wrap_fetch_timeout");
    cycle();

    // Memory not ready: address and valid held.
    imem_req_ready = 1'b0;
    repeat (4) begin
      cycle();
      chk("busy_rq", {31'b0, last_rq}, 32'h1);
      chk("busy_addr", last_addr, 32'h4);
    end
    imem_req_ready = 1'b1;

    // Random traffic.
    lat_fix = 0;
    for (int i = 0; i < 800; i++) begin
      imem_req_ready = ($urandom_range(0, 9) < 7);
      stall_in       = ($urandom_range(0, 9) < 3);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      cycle();
    end
    redirect_valid = 1'b0; stall_in = 1'b0; imem_req_ready = 1'b1;
    chk("random_progress", {31'b0, presented > 40}, 32'h1);

    // Reset asserted while a fetch is in flight.
    lat_fix = 3;
    for (int n = 0; n < 20; n++) begin
      cycle();
      if (last_rq) break;
    end
    chk("pre_reset_rq", {31'b0, last_rq}, 32'h1);
    #2;
    do_reset();
    lat_fix = 1;
    cycle();
    chk("restart_addr", last_addr, 32'h0);
    run_until_valid("restart_fetch1");
    cycle();
    run_until_valid("restart_fetch2");
    cycle();
`ifdef IFETCH_PERF_CNT_EN
    chk("two_consumed", fetch_count, 32'd2);
`else
    chk("no_counter", fetch_count, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
